// File: rtl/rtc_bus_if.sv
// Request/response and pin-strobe bundle between the RTC control FSM and rtc_bus_driver.
// start is a one-cycle request taken only while busy=0; done pulses for one cycle when the access ends.
interface rtc_bus_if;
  logic       start;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       a_d;
  logic       cs;
  logic       rd;
  logic       wr;
  logic       drive_en;
  logic [3:0] state;

  modport master (
    output start, rw, addr, wdata,
    input  rdata, busy, done, a_d, cs, rd, wr, drive_en, state
  );

  modport slave (
    input  start, rw, addr, wdata,
    output rdata, busy, done, a_d, cs, rd, wr, drive_en, state
  );
endinterface

// File: rtl/rtc_bus_driver.sv
// Two-phase (address, then data) timed access engine for the RTC multiplexed bus.
// All pins and the bus drive-enable come straight from flops, decoded from the next state.
module rtc_bus_driver #(
  parameter int unsigned T_SU  = 4,
  parameter int unsigned T_PW  = 8,
  parameter int unsigned T_HD  = 4,
  parameter int unsigned T_GAP = 6
) (
  input  logic       clk,
  input  logic       reset,
  rtc_bus_if.slave   bus,
  inout  wire  [7:0] dato
);

  typedef enum logic [3:0] {
    IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic       rw_q, rw_n;
  logic [7:0] addr_q, addr_n, wdata_q, wdata_n;
  logic       accept;

  logic       a_d_q, cs_q, rd_q, wr_q, den_q, busy_q, done_q;
  logic       a_d_n, cs_n, rd_n, wr_n, den_n, busy_n, done_n;
  logic [7:0] dout_q, dout_n, rdata_q;

  function automatic logic [7:0] dur(input state_t s);
    case (s)
      A_SU, D_SU: dur = 8'(T_SU);
      A_PW, D_PW: dur = 8'(T_PW);
      A_HD, D_HD: dur = 8'(T_HD);
      GAP:        dur = 8'(T_GAP);
      DONE:       dur = 8'd1;
      default:    dur = 8'd0;
    endcase
  endfunction

  assign accept  = (state == IDLE) && bus.start;
  assign rw_n    = accept ? bus.rw    : rw_q;
  assign addr_n  = accept ? bus.addr  : addr_q;
  assign wdata_n = accept ? bus.wdata : wdata_q;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = A_SU;
      DONE:    state_n = IDLE;
      default: begin
        if (cnt == 8'd1) begin
          case (state)
            A_SU:    state_n = A_PW;
            A_PW:    state_n = A_HD;
            A_HD:    state_n = GAP;
            GAP:     state_n = D_SU;
            D_SU:    state_n = D_PW;
            D_PW:    state_n = D_HD;
            default: state_n = DONE;
          endcase
        end
      end
    endcase

    // No state is its own successor, so a state change always means a fresh load.
    cnt_n = cnt;
    if (state_n != state)  cnt_n = dur(state_n);
    else if (cnt != 8'd0)  cnt_n = cnt - 8'd1;
  end

  always_comb begin
    a_d_n  = 1'b1;
    cs_n   = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    den_n  = 1'b0;
    dout_n = 8'h00;
    busy_n = 1'b1;
    done_n = 1'b0;
    case (state_n)
      IDLE: busy_n = 1'b0;
      A_SU, A_HD: begin
        a_d_n  = 1'b0;
        den_n  = 1'b1;
        dout_n = addr_n;
      end
      A_PW: begin
        a_d_n  = 1'b0;
        den_n  = 1'b1;
        dout_n = addr_n;
        cs_n   = 1'b0;
        wr_n   = 1'b0;
      end
      D_SU, D_HD: begin
        den_n  = ~rw_n;
        dout_n = wdata_n;
      end
      D_PW: begin
        cs_n   = 1'b0;
        rd_n   = ~rw_n;
        wr_n   = rw_n;
        den_n  = ~rw_n;
        dout_n = wdata_n;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      a_d_q   <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      den_q   <= 1'b0;
      dout_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rw_q    <= rw_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      a_d_q   <= a_d_n;
      cs_q    <= cs_n;
      rd_q    <= rd_n;
      wr_q    <= wr_n;
      den_q   <= den_n;
      dout_q  <= dout_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      // Sample on the final cycle of the read strobe, while the chip still drives.
      if (state == D_PW && cnt == 8'd1 && rw_q) rdata_q <= dato;
    end
  end

  assign dato         = den_q ? dout_q : 8'hzz;
  assign bus.a_d      = a_d_q;
  assign bus.cs       = cs_q;
  assign bus.rd       = rd_q;
  assign bus.wr       = wr_q;
  assign bus.drive_en = den_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.state    = state;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Self-checking bench for rtc_bus_driver: per-cycle pin timeline plus a read-data scoreboard.
module tb_rtc_bus_driver;

  localparam int D_SU = 4, D_PW = 8, D_HD = 4, D_GAP = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rtc_bus_if bus0 ();
  rtc_bus_if bus1 ();
  wire [7:0] dato0, dato1;
  logic [7:0] model_val = 8'h37;

  // RTC chip model: drives its register value whenever the read strobe is low.
  assign dato0 = (bus0.rd == 1'b0) ? model_val : 8'hzz;
  assign dato1 = (bus1.rd == 1'b0) ? model_val : 8'hzz;

  rtc_bus_driver dut0 (.clk(clk), .reset(reset), .bus(bus0), .dato(dato0));
  rtc_bus_driver #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1), .dato(dato1));

  typedef struct packed {
    logic a_d, cs, rd, wr, den, busy, done;
    logic [7:0] dato;
    logic [7:0] rdata;
    logic [3:0] st;
  } pins_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic sample(input bit sel, output pins_t p);
    if (sel) p = '{bus1.a_d, bus1.cs, bus1.rd, bus1.wr, bus1.drive_en, bus1.busy,
                   bus1.done, dato1, bus1.rdata, bus1.state};
    else     p = '{bus0.a_d, bus0.cs, bus0.rd, bus0.wr, bus0.drive_en, bus0.busy,
                   bus0.done, dato0, bus0.rdata, bus0.state};
  endtask

  task automatic drive_req(input bit sel, input bit s, input bit r,
                           input logic [7:0] a, input logic [7:0] w);
    if (sel) begin bus1.start = s; bus1.rw = r; bus1.addr = a; bus1.wdata = w; end
    else     begin bus0.start = s; bus0.rw = r; bus0.addr = a; bus0.wdata = w; end
  endtask

  task automatic check_reset_vals(input string tag);
    pins_t p;
    sample(1'b0, p);
    check({tag, "_a_d"},   p.a_d, 1);
    check({tag, "_strb"},  {p.cs, p.rd, p.wr}, 3'b111);
    check({tag, "_den"},   p.den, 0);
    check({tag, "_busy"},  p.busy, 0);
    check({tag, "_done"},  p.done, 0);
    check({tag, "_rdata"}, p.rdata, 8'h00);
    check({tag, "_state"}, p.st, 0);
  endtask

  // One full access, checked cycle by cycle against the phase boundaries derived from the timing params.
  task automatic run_txn(input bit sel, input bit rw, input logic [7:0] addr, input logic [7:0] wdata,
                         input int su, input int pw, input int hd, input int gap,
                         input int abort_at, input bit inject);
    pins_t p;
    int a_end, apw_s, apw_e, g_e, dpw_s, dpw_e, d_e, done_c;
    logic e_a_d, e_cs, e_rd, e_wr, e_den, e_busy, e_done;
    logic [7:0] e_val;
    a_end = su + pw + hd;  apw_s = su + 1;  apw_e = su + pw;
    g_e   = a_end + gap;   dpw_s = g_e + su + 1;  dpw_e = g_e + su + pw;
    d_e   = g_e + su + pw + hd;  done_c = d_e + 1;

    @(posedge clk); #1;
    sample(sel, p);
    check($sformatf("idle_busy_s%0d", sel), p.busy, 0);
    drive_req(sel, 1'b1, rw, addr, wdata);
    if (!sel) begin
      exp_q.push_back(rw ? model_val : last_rd);
      if (rw) last_rd = model_val;
    end
    @(posedge clk); #1;
    drive_req(sel, 1'b0, ~rw, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    for (int i = 1; i <= done_c; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      sample(sel, p);
      e_a_d = 1; e_cs = 1; e_rd = 1; e_wr = 1; e_den = 0; e_done = 0; e_val = 8'h00;
      e_busy = 1;
      if (i <= a_end) begin
        e_a_d = 0; e_den = 1; e_val = addr;
        if (i >= apw_s && i <= apw_e) begin e_cs = 0; e_wr = 0; end
      end else if (i > g_e && i <= d_e) begin
        e_den = ~rw; e_val = wdata;
        if (i >= dpw_s && i <= dpw_e) begin
          e_cs = 0;
          if (rw) e_rd = 0; else e_wr = 0;
        end
      end else if (i == done_c) e_done = 1;
      check($sformatf("a_d_c%0d", i),  p.a_d, e_a_d);
      check($sformatf("cs_c%0d", i),   p.cs,  e_cs);
      check($sformatf("rd_c%0d", i),   p.rd,  e_rd);
      check($sformatf("wr_c%0d", i),   p.wr,  e_wr);
      check($sformatf("den_c%0d", i),  p.den, e_den);
      check($sformatf("busy_c%0d", i), p.busy, e_busy);
      check($sformatf("done_c%0d", i), p.done, e_done);
      if (e_den) check($sformatf("dato_c%0d", i), p.dato, e_val);

      if (inject && (i == 10 || i == 38))
        drive_req(sel, 1'b1, ~rw, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      else
        drive_req(sel, 1'b0, rw, addr, wdata);

      if (abort_at != 0 && i == abort_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        last_rd = 8'h00;
        check_reset_vals("abort");
        return;
      end
    end
  endtask

  // Scoreboard: every done must match the oldest expected read-data entry.
  always @(negedge clk) begin
    if (!reset && bus0.done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 1, 0);
      else check("sb_rdata", bus0.rdata, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive_req(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;

    // Write with busy-time start pulses, then a read accepted right after DONE.
    run_txn(1'b0, 1'b0, 8'h21, 8'h45, D_SU, D_PW, D_HD, D_GAP, 0, 1'b1);
    run_txn(1'b0, 1'b1, 8'h22, 8'h00, D_SU, D_PW, D_HD, D_GAP, 0, 1'b0);

    // Write aborted by reset during the data strobe, then normal traffic resumes.
    run_txn(1'b0, 1'b0, 8'h5a, 8'hc3, D_SU, D_PW, D_HD, D_GAP, 28, 1'b0);
    model_val = 8'($urandom_range(0, 255));
    run_txn(1'b0, 1'b1, 8'($urandom_range(0, 255)), 8'h00, D_SU, D_PW, D_HD, D_GAP, 0, 1'b0);
    run_txn(1'b0, 1'b0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            D_SU, D_PW, D_HD, D_GAP, 0, 1'b0);

    // Minimum-timing instance.
    run_txn(1'b1, 1'b0, 8'h0f, 8'hf0, 1, 1, 1, 1, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
